// File: rtl/dma_pkg.sv
// Shared definitions for the DMA bus arbiter and the DMA controller:
// arbiter FSM states and the default memory-cycle pacing constants.
package dma_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_CPU = 2'd1,
        GRANT    = 2'd2,
        RELEASE  = 2'd3
    } arb_state_t;

    localparam int DMA_MEM_LATENCY = 5;
    localparam int DMA_CTR_W       = 3;

    // Width needed to hold a count of 0..max_value inclusive.
    function automatic int count_width(input int max_value);
        return (max_value < 2) ? 1 : $clog2(max_value + 1);
    endfunction

endpackage

// File: rtl/dma_cycle_counter.sv
// Wrapping memory-cycle counter: counts 0..MAX_COUNT while enabled and
// flags the last cycle of each chunk. Clear has priority over enable.
module dma_cycle_counter
    import dma_pkg::*;
#(
    parameter int MAX_COUNT = DMA_MEM_LATENCY,
    parameter int CTR_W     = DMA_CTR_W
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             en,
    input  logic             clr,
    output logic [CTR_W-1:0] count,
    output logic             chunk_done
);

    localparam logic [CTR_W-1:0] LAST = CTR_W'(MAX_COUNT);

    logic [CTR_W-1:0] count_reg;
    logic [CTR_W-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (clr) begin
            count_next = '0;
        end else if (en) begin
            // Wrap at MAX_COUNT rather than at the natural 2**CTR_W rollover.
            count_next = (count_reg == LAST) ? '0 : count_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign count      = count_reg;
    assign chunk_done = en && (count_reg == LAST);

endmodule

// File: rtl/dma_bus_arbiter.sv
// CPU-side bus arbiter ahead of the DMA controller: grants the bus, stalls the
// CPU, paces chunks and latches the DMA interrupt. Optional: ARB_TIMEOUT_EN.
module dma_bus_arbiter
    import dma_pkg::*;
#(
    parameter int MEM_LATENCY    = DMA_MEM_LATENCY,
    parameter int CTR_W          = DMA_CTR_W,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             BR,
    input  logic             cpu_mem_busy,
    input  logic             interrupt,
    input  logic             intr_ack,
    output logic             BG,
    output logic             cpu_stall,
    output logic [CTR_W-1:0] clk_counter,
    output logic             chunk_done,
    output logic             intr_pending,
    output logic             bus_error
);

    if (MEM_LATENCY >= (2 ** CTR_W) || MEM_LATENCY < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("dma_bus_arbiter: MEM_LATENCY must be in 1..2**CTR_W-1 and TIMEOUT_CYCLES >= 1");
    end

    arb_state_t state_reg;
    arb_state_t state_next;
    logic       bg_reg;
    logic       bg_next;
    logic       stall_reg;
    logic       stall_next;
    logic       timeout_hit;
    logic       grant_blocked;
    logic       intr_d_reg;
    logic       intr_pending_reg;

`ifdef ARB_TIMEOUT_EN
    localparam int GW = count_width(TIMEOUT_CYCLES);

    logic [GW-1:0] grant_cnt_reg;
    logic          bus_error_reg;

    // Counts BG=1 cycles; clears on the same edge the grant ends.
    always_ff @(posedge clk) begin
        if (reset || !bg_next) begin
            grant_cnt_reg <= '0;
        end else if (bg_reg) begin
            grant_cnt_reg <= grant_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus_error_reg <= 1'b0;
        end else if (timeout_hit) begin
            bus_error_reg <= 1'b1;
        end
    end

    assign timeout_hit   = bg_reg && BR && (grant_cnt_reg == GW'(TIMEOUT_CYCLES - 1));
    assign grant_blocked = bus_error_reg;
    assign bus_error     = bus_error_reg;
`else
    assign timeout_hit   = 1'b0;
    assign grant_blocked = 1'b0;
    assign bus_error     = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (BR && !grant_blocked) begin
                    state_next = cpu_mem_busy ? WAIT_CPU : GRANT;
                end
            end
            WAIT_CPU: begin
                // A withdrawn request wins over the CPU going idle.
                if (!BR) begin
                    state_next = IDLE;
                end else if (!cpu_mem_busy) begin
                    state_next = GRANT;
                end
            end
            GRANT: begin
                if (!BR || timeout_hit) begin
                    state_next = RELEASE;
                end
            end
            RELEASE:  state_next = IDLE;
            default:  state_next = IDLE;
        endcase

        // BG rises one cycle after GRANT entry but falls on the leaving edge.
        bg_next    = (state_reg == GRANT) && (state_next == GRANT);
        // Entering GRANT straight from IDLE delays the stall like BG; coming
        // from WAIT_CPU the stall is already up and must not glitch low.
        stall_next = (state_next == WAIT_CPU) || (state_next == RELEASE) ||
                     ((state_next == GRANT) && (state_reg != IDLE));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            bg_reg    <= 1'b0;
            stall_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            bg_reg    <= bg_next;
            stall_reg <= stall_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            intr_d_reg       <= 1'b0;
            intr_pending_reg <= 1'b0;
        end else begin
            intr_d_reg <= interrupt;
            if (interrupt && !intr_d_reg) begin
                intr_pending_reg <= 1'b1;
            end else if (intr_ack) begin
                intr_pending_reg <= 1'b0;
            end
        end
    end

    dma_cycle_counter #(
        .MAX_COUNT (MEM_LATENCY),
        .CTR_W     (CTR_W)
    ) u_cycle_counter (
        .clk        (clk),
        .srst       (reset),
        .en         (bg_reg),
        .clr        (!bg_next),
        .count      (clk_counter),
        .chunk_done (chunk_done)
    );

    assign BG           = bg_reg;
    assign cpu_stall    = stall_reg;
    assign intr_pending = intr_pending_reg;

endmodule
